// File: rtl/alu_pkg.sv
// Shared definitions for the Hack-style ALU pipeline: datapath width,
// control-bit positions, common control encodings and pipeline word types.
package alu_pkg;

  localparam int WORD_W = 16;

  // Bit positions inside ctrl = {zx,nx,zy,ny,f,no}
  localparam int CTRL_ZX = 5;
  localparam int CTRL_NX = 4;
  localparam int CTRL_ZY = 3;
  localparam int CTRL_NY = 2;
  localparam int CTRL_F  = 1;
  localparam int CTRL_NO = 0;

  // Frequently used control words
  localparam logic [5:0] ALU_ADD   = 6'b000010;
  localparam logic [5:0] ALU_ZERO  = 6'b101010;
  localparam logic [5:0] ALU_NEG_X = 6'b001111;
  localparam logic [5:0] ALU_AND   = 6'b000000;

  // Contents of stage 1: preprocessed operands plus the function bits
  typedef struct packed {
    logic [WORD_W-1:0] x;
    logic [WORD_W-1:0] y;
    logic              f;
    logic              no;
  } s1_word_t;

  // Signed-add overflow: operands agree in sign but the sum does not
  function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                   input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_pre.sv
// Operand preprocessing for one ALU input: optional zeroing followed by
// optional bitwise negation. Purely combinational.
module alu_pre
  import alu_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic              z,
  input  logic              n,
  output logic [WORD_W-1:0] a_o
);

  logic [WORD_W-1:0] a_z;

  // Zero first, then negate, so zx+nx yields all-ones
  always_comb begin
    a_z = z ? '0 : a;
    a_o = n ? ~a_z : a_z;
  end

endmodule

// File: rtl/or_16_way.sv
// 16-input OR reduction; output is high when any input bit is set.
module or_16_way (
  input  logic [15:0] in,
  output logic        out
);

  assign out = |in;

endmodule

// File: rtl/alu_pipe_stage.sv
// Two-stage pipelined Hack ALU with valid/ready handshakes on both sides.
// Stage 1 holds preprocessed operands; stage 2 is the registered output
// (out/zr/ng and, when ALU_OVF_FLAG_EN is defined, ov).
//
// Handshake: a word transfers on a rising clk edge where valid && ready are
// both high; the producer keeps its word stable until it transfers, and ready
// never depends combinationally on valid of the same interface.
module alu_pipe_stage
  import alu_pkg::*;
#(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_OUT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
`ifdef ALU_OVF_FLAG_EN
  ,
  output logic             ov
`endif
);

  // or_16_way is fixed-width, so no other datapath width can work
  generate
    if (WIDTH != WORD_W) begin : g_width_check
      $error("alu_pipe_stage: WIDTH must be 16");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Handshake / advance control
  // ---------------------------------------------------------------------
  logic     s1_valid_q, s1_valid_d;
  logic     s2_valid_q, s2_valid_d;
  s1_word_t s1_q, s1_d;
  logic     s2_adv, s1_adv, in_acc;

  // Stage 2 can take a word when empty or when its word leaves this cycle
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_adv;
    in_ready = !rst && (!s1_valid_q || s2_adv);
    in_acc   = in_valid && in_ready;
  end

  // ---------------------------------------------------------------------
  // Stage 1: operand preprocessing in front of the register
  // ---------------------------------------------------------------------
  logic [WORD_W-1:0] x_pre, y_pre;

  alu_pre u_pre_x (
    .a   (x),
    .z   (ctrl[CTRL_ZX]),
    .n   (ctrl[CTRL_NX]),
    .a_o (x_pre)
  );

  alu_pre u_pre_y (
    .a   (y),
    .z   (ctrl[CTRL_ZY]),
    .n   (ctrl[CTRL_NY]),
    .a_o (y_pre)
  );

  // Stage 1 loads on accept, empties when its word moves into stage 2
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (in_acc) begin
      s1_valid_d = 1'b1;
      s1_d.x     = x_pre;
      s1_d.y     = y_pre;
      s1_d.f     = ctrl[CTRL_F];
      s1_d.no    = ctrl[CTRL_NO];
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 1 registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: function, output negation and flags
  // ---------------------------------------------------------------------
  logic [WORD_W-1:0] sum, r_fn, r;
  logic              r_any;
  logic [WORD_W-1:0] out_q, out_d;
  logic              zr_q, zr_d;
  logic              ng_q, ng_d;

  // Add drops the carry; no inverts after the function is applied
  always_comb begin
    sum  = s1_q.x + s1_q.y;
    r_fn = s1_q.f ? sum : (s1_q.x & s1_q.y);
    r    = s1_q.no ? ~r_fn : r_fn;
  end

  or_16_way u_zr (
    .in  (r),
    .out (r_any)
  );

`ifdef ALU_OVF_FLAG_EN
  logic ov_q, ov_d;
  logic ov_raw;

  // Overflow is judged on the raw sum, before the no inversion
  always_comb begin
    ov_raw = s1_q.f && add_ovf(s1_q.x[WORD_W-1], s1_q.y[WORD_W-1], sum[WORD_W-1]);
  end
`endif

  // Output stage loads only when it may advance; otherwise it holds
  always_comb begin
    s2_valid_d = s2_valid_q;
    out_d      = out_q;
    zr_d       = zr_q;
    ng_d       = ng_q;
`ifdef ALU_OVF_FLAG_EN
    ov_d       = ov_q;
`endif
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d = r;
        zr_d  = ~r_any;
        ng_d  = r[WORD_W-1];
`ifdef ALU_OVF_FLAG_EN
        ov_d  = ov_raw;
`endif
      end
    end
  end

  // Output stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      out_q      <= RESET_OUT;
      zr_q       <= 1'b0;
      ng_q       <= 1'b0;
`ifdef ALU_OVF_FLAG_EN
      ov_q       <= 1'b0;
`endif
    end else begin
      s2_valid_q <= s2_valid_d;
      out_q      <= out_d;
      zr_q       <= zr_d;
      ng_q       <= ng_d;
`ifdef ALU_OVF_FLAG_EN
      ov_q       <= ov_d;
`endif
    end
  end

  assign out_valid = s2_valid_q;
  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
`ifdef ALU_OVF_FLAG_EN
  assign ov        = ov_q;
`endif

endmodule

// File: tb/tb_alu_pipe_stage.sv
// Bench for alu_pipe_stage: directed cases, randomised traffic with random
// output back-pressure, a stall/fill case and a mid-flight reset.
// Build with ALU_OVF_FLAG_EN defined to also cover the ov flag.
module tb_alu_pipe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x, y;
  logic [5:0]  ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        zr, ng;
`ifdef ALU_OVF_FLAG_EN
  logic        ov;
`endif

  int checks   = 0;
  int failures = 0;

  // {ov, zr, ng, out}
  logic [18:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  alu_pipe_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zr        (zr),
    .ng        (ng)
`ifdef ALU_OVF_FLAG_EN
    ,
    .ov        (ov)
`endif
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference Hack ALU
  function automatic logic [18:0] model(input logic [15:0] xv, input logic [15:0] yv,
                                        input logic [5:0] c);
    logic [15:0] xa, ya, s, res;
    logic        o, z, n;
    xa = c[5] ? 16'h0000 : xv;
    if (c[4]) xa = ~xa;
    ya = c[3] ? 16'h0000 : yv;
    if (c[2]) ya = ~ya;
    s   = xa + ya;
    res = c[1] ? s : (xa & ya);
    o   = c[1] & (xa[15] == ya[15]) & (s[15] != xa[15]);
    if (c[0]) res = ~res;
    z = (res == 16'h0000);
    n = res[15];
    return {o, z, n, res};
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic        prev_stall = 1'b0;
  logic [15:0] prev_out   = '0;

  always @(negedge clk) begin
    logic [18:0] e;
    if (!rst) begin
      if (prev_stall && out_valid) check("hold_out", out, prev_out);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out", out, e[15:0]);
          check("zr", zr, e[17]);
          check("ng", ng, e[16]);
`ifdef ALU_OVF_FLAG_EN
          check("ov", ov, e[18]);
`endif
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = out;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- drivers ----------------
  // Present a word and hold it until accepted; optionally randomise out_ready
  task automatic send(input logic [15:0] xv, input logic [15:0] yv,
                      input logic [5:0] cv, input bit rnd);
    int  waited;
    bit  done;
    waited   = 0;
    done     = 0;
    in_valid = 1'b1;
    x        = xv;
    y        = yv;
    ctrl     = cv;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(xv, yv, cv));
        done = 1;
      end
      @(posedge clk);
      #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      waited++;
      if (!done && waited > 100) begin
        check("accept_timeout", 32'd1, 32'd0);
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] w0_out;
    logic [15:0] rx, ry;
    logic [5:0]  rc;
    logic [5:0]  ctrl_tab [6];
    logic        rdy_seen [3];

    ctrl_tab[0] = 6'b000010; ctrl_tab[1] = 6'b000000; ctrl_tab[2] = 6'b010011;
    ctrl_tab[3] = 6'b000111; ctrl_tab[4] = 6'b010101; ctrl_tab[5] = 6'b110111;

    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; ctrl = '0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out", out, 16'h0000);
    check("rst_zr", zr, 1'b0);
    check("rst_ng", ng, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // 5 + 3 with latency check on an empty pipe
    send(16'd5, 16'd3, 6'b000010, 0);
    check("lat_not_yet", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check("lat_valid", out_valid, 1'b1);
    drain();

    // Directed: constant 0, -x, overflow boundary, then 0+0
    send(16'h1234, 16'hABCD, 6'b101010, 0);
    send(16'h0001, 16'h5555, 6'b001111, 0);
    send(16'h7FFF, 16'h0001, 6'b000010, 0);
    send(16'h0000, 16'h0000, 6'b000010, 0);
    send(16'hFFFF, 16'hFFFF, 6'b000010, 0);
    drain();

    // Random traffic with random output back-pressure
    for (int i = 0; i < 40; i++) begin
      rx = 16'($urandom_range(0, 65535));
      ry = 16'($urandom_range(0, 65535));
      rc = (i % 3 == 0) ? 6'($urandom_range(0, 63)) : ctrl_tab[i % 6];
      send(rx, ry, rc, 1);
    end
    drain();

    // Stall: out_ready low, three words back to back
    @(posedge clk);
    #1 out_ready = 1'b0;
    w0_out = model(16'd10, 16'd20, 6'b000010) >> 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      x = 16'(10 * (i + 1)); y = 16'(20 * (i + 1)); ctrl = 6'b000010;
      @(negedge clk);
      rdy_seen[i] = in_ready;
      if (in_ready) exp_q.push_back(model(x, y, ctrl));
      @(posedge clk);
      #1;
    end
    check("stall_rdy0", rdy_seen[0], 1'b1);
    check("stall_rdy1", rdy_seen[1], 1'b1);
    check("stall_rdy2", rdy_seen[2], 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1'b1);
      check("stall_out", out, w0_out);
      check("stall_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("resume_valid0", out_valid, 1'b1);
    check("resume_in_ready", in_ready, 1'b1);
    if (in_ready) exp_q.push_back(model(x, y, ctrl));
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("resume_valid1", out_valid, 1'b1);
    @(negedge clk);
    check("resume_valid2", out_valid, 1'b1);
    drain();

    // Reset with two words in flight
    send(16'h0100, 16'h0022, 6'b000010, 0);
    send(16'h0300, 16'h0044, 6'b000010, 0);
    check("inflight_valid", out_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_in_ready", in_ready, 1'b0);
    check("async_out", out, 16'h0000);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("rel_no_output", out_valid, 1'b0);
      @(negedge clk);
    end

    // Pipe still works after reset
    send(16'h0002, 16'h0003, 6'b000010, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
